comp_share_arb: RTL and testbench

COMP_SHARE_ARB -- requirements
Module: comp_share_arb

---
 rtl/comp_share_arb.sv | 136 +++++++++++++
 tb/tb_comp_share_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/comp_share_arb.sv
// Round-robin arbiter sharing one unsigned magnitude comparator (4-bit slices, MSB first) among NUM_REQ requesters.
// Latency: handshake in cycle N -> o_rsp_valid in N+2; issue interval >= 3 cycles. COMP_SHARE_ARB_SWAP_EN adds max/min outputs.
// Backpressure: o_req_ready only in IDLE; response held in RESPOND until i_rsp_ready; waiting requests are never dropped.
module comp_share_arb #(
   parameter int SIZE_DATA = 28,
   parameter int NUM_REQ   = 4,
   localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [NUM_REQ-1:0]             i_req_valid,
   output logic [NUM_REQ-1:0]             o_req_ready,
   input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_data_a,
   input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_data_b,
   output logic                           o_rsp_valid,
   input  logic                           i_rsp_ready,
   output logic [ID_W-1:0]                o_rsp_id,
   output logic                           o_rsp_less,
`ifdef COMP_SHARE_ARB_SWAP_EN
   output logic                           o_rsp_equal,
   output logic [SIZE_DATA-1:0]           o_rsp_max,
   output logic [SIZE_DATA-1:0]           o_rsp_min
`else
   output logic                           o_rsp_equal
`endif
);

   localparam int NSL = SIZE_DATA / 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPARE,
      ST_RESPOND
   } state_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       lat_id;
   logic [SIZE_DATA-1:0]  lat_a, lat_b;
   logic [ID_W-1:0]       cand;
   logic [ID_W-1:0]       gnt_idx;
   logic                  gnt_found;
   logic                  hs;
   logic                  cmp_lt, cmp_eq;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s[ID_W-1:0];
   endfunction

   // First valid requester at or after the round-robin pointer.
   always_comb begin
      cand      = '0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = wrap_add(rr_ptr, i);
         if (!gnt_found && i_req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Slice chain: a higher slice that differs decides; lower slices only matter while all above are equal.
   always_comb begin
      cmp_lt = 1'b0;
      cmp_eq = 1'b1;
      for (int s = NSL - 1; s >= 0; s--) begin
         cmp_lt = cmp_lt | (cmp_eq & (lat_a[s*4 +: 4] < lat_b[s*4 +: 4]));
         cmp_eq = cmp_eq & (lat_a[s*4 +: 4] == lat_b[s*4 +: 4]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      o_req_ready = '0;
      o_rsp_valid = 1'b0;
      hs          = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (gnt_found && !i_rst) begin
               o_req_ready = NUM_REQ'(1) << gnt_idx;
               hs          = 1'b1;
               state_nxt   = ST_COMPARE;
            end
         end
         ST_COMPARE: state_nxt = ST_RESPOND;
         ST_RESPOND: begin
            o_rsp_valid = !i_rst;
            if (i_rsp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr_ptr      <= '0;
         lat_id      <= '0;
         lat_a       <= '0;
         lat_b       <= '0;
         o_rsp_id    <= '0;
         o_rsp_less  <= 1'b0;
         o_rsp_equal <= 1'b0;
`ifdef COMP_SHARE_ARB_SWAP_EN
         o_rsp_max   <= '0;
         o_rsp_min   <= '0;
`endif
      end else begin
         if (hs) begin
            lat_a  <= i_req_data_a[gnt_idx*SIZE_DATA +: SIZE_DATA];
            lat_b  <= i_req_data_b[gnt_idx*SIZE_DATA +: SIZE_DATA];
            lat_id <= gnt_idx;
            rr_ptr <= wrap_add(gnt_idx, 1);
         end
         if (state == ST_COMPARE) begin
            o_rsp_id    <= lat_id;
            o_rsp_less  <= cmp_lt;
            o_rsp_equal <= cmp_eq;
`ifdef COMP_SHARE_ARB_SWAP_EN
            o_rsp_max   <= cmp_lt ? lat_b : lat_a;
            o_rsp_min   <= cmp_lt ? lat_a : lat_b;
`endif
         end
      end
   end

endmodule

// File: tb/tb_comp_share_arb.sv
// Directed bench for comp_share_arb: reset, latency, round-robin, compare corners, backpressure, reset mid-flight.
module tb_comp_share_arb;

   localparam int SD   = 28;
   localparam int NREQ = 4;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*SD-1:0]   req_a, req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [1:0]           rsp_id;
   logic                 rsp_less, rsp_equal;
`ifdef COMP_SHARE_ARB_SWAP_EN
   logic [SD-1:0]        rsp_max, rsp_min;
`endif

   int n_vec = 0;
   int n_err = 0;

   comp_share_arb #(.SIZE_DATA(SD), .NUM_REQ(NREQ)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_data_a (req_a),
      .i_req_data_b (req_b),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_id     (rsp_id),
      .o_rsp_less   (rsp_less),
`ifdef COMP_SHARE_ARB_SWAP_EN
      .o_rsp_equal  (rsp_equal),
      .o_rsp_max    (rsp_max),
      .o_rsp_min    (rsp_min)
`else
      .o_rsp_equal  (rsp_equal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // One isolated transaction from requester k, starting and ending in IDLE.
   task automatic run_txn(input int k, input logic [SD-1:0] a, input logic [SD-1:0] b,
                          output logic [NREQ-1:0] rdy, output logic vld_early, output logic vld,
                          output logic [1:0] id, output logic lt, output logic eq);
      req_a = '0;
      req_b = '0;
      req_a[k*SD +: SD] = a;
      req_b[k*SD +: SD] = b;
      req_valid = 4'b0001 << k;
      rsp_ready = 1'b1;
      #1 rdy = req_ready;
      tick();
      req_valid = '0;
      vld_early = rsp_valid;
      tick();
      vld = rsp_valid;
      id  = rsp_id;
      lt  = rsp_less;
      eq  = rsp_equal;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 4'b1111;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
      n_vec++; if ({rsp_less, rsp_equal} !== 2'b00) begin n_err++; $display("FAIL reset_less_equal: got %b want 00", {rsp_less, rsp_equal}); end
      rst = 1'b0;
      req_valid = '0;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL idle_no_req_ready: got %b want 0000", req_ready); end
      tick();
   endtask

   task automatic test_single();
      logic [NREQ-1:0] rdy;
      logic vld_e, vld, lt, eq;
      logic [1:0] id;
      run_txn(2, 28'h0000010, 28'h0000011, rdy, vld_e, vld, id, lt, eq);
      n_vec++; if (rdy !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", rdy); end
      n_vec++; if (vld_e !== 1'b0) begin n_err++; $display("FAIL single_valid_n1: got %b want 0", vld_e); end
      n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL single_valid_n2: got %b want 1", vld); end
      n_vec++; if (id !== 2'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", id); end
      n_vec++; if ({lt, eq} !== 2'b10) begin n_err++; $display("FAIL single_less_equal: got %b want 10", {lt, eq}); end
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_after: got %b want 0", rsp_valid); end
      n_vec++; if ({rsp_id, rsp_less, rsp_equal} !== 4'b1010) begin n_err++; $display("FAIL single_hold: got %b want 1010", {rsp_id, rsp_less, rsp_equal}); end
   endtask

   task automatic test_round_robin();
      int   exp_g[5]  = '{0, 1, 2, 3, 0};
      logic exp_lt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic exp_eq[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         req_a[k*SD +: SD] = SD'(k);
         req_b[k*SD +: SD] = SD'(2);
      end
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         #1;
         n_vec++; if (req_ready !== (4'b0001 << exp_g[g])) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, 4'b0001 << exp_g[g]); end
         tick();
         n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rr_compare_ready%0d: got %b want 0000", g, req_ready); end
         tick();
         n_vec++; if ({rsp_valid, req_ready} !== 5'b10000) begin n_err++; $display("FAIL rr_respond%0d: got %b want 10000", g, {rsp_valid, req_ready}); end
         n_vec++; if (rsp_id !== 2'(exp_g[g])) begin n_err++; $display("FAIL rr_id%0d: got %0d want %0d", g, rsp_id, exp_g[g]); end
         n_vec++; if ({rsp_less, rsp_equal} !== {exp_lt[g], exp_eq[g]}) begin n_err++; $display("FAIL rr_cmp%0d: got %b want %b", g, {rsp_less, rsp_equal}, {exp_lt[g], exp_eq[g]}); end
         tick();
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_compare_bounds();
      logic [SD-1:0] va[5]  = '{28'hFFFFFFF, 28'h8000000, 28'h7FFFFFF, 28'h1234567, 28'h0000000};
      logic [SD-1:0] vb[5]  = '{28'hFFFFFFF, 28'h7FFFFFF, 28'h8000000, 28'h1234568, 28'h0000000};
      logic [1:0]    ve[5]  = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b01};
      logic [NREQ-1:0] rdy;
      logic vld_e, vld, lt, eq;
      logic [1:0] id;
      for (int v = 0; v < 5; v++) begin
         run_txn(1, va[v], vb[v], rdy, vld_e, vld, id, lt, eq);
         n_vec++; if ({rdy, vld, id} !== 7'b0010_1_01) begin n_err++; $display("FAIL bound%0d_handshake: got %b want 0010101", v, {rdy, vld, id}); end
         n_vec++; if ({lt, eq} !== ve[v]) begin n_err++; $display("FAIL bound%0d_cmp: a=%h b=%h got %b want %b", v, va[v], vb[v], {lt, eq}, ve[v]); end
      end
   endtask

   task automatic test_backpressure();
      req_a = '0;
      req_b = '0;
      req_a[3*SD +: SD] = 28'h0000005;
      req_b[3*SD +: SD] = 28'h0000003;
      req_valid = 4'b1000;
      rsp_ready = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
      tick();
      req_valid = 4'b0001;
      tick();
      for (int c = 0; c < 5; c++) begin
         n_vec++; if ({rsp_valid, rsp_id, rsp_less, rsp_equal, req_ready} !== 9'b1_11_0_0_0000) begin
            n_err++; $display("FAIL bp_hold%0d: got %b want 111000000", c, {rsp_valid, rsp_id, rsp_less, rsp_equal, req_ready});
         end
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_release_valid: got %b want 1", rsp_valid); end
      tick();
      n_vec++; if ({rsp_valid, req_ready} !== 5'b0_0001) begin n_err++; $display("FAIL bp_after: got %b want 00001", {rsp_valid, req_ready}); end
      tick();
      req_valid = '0;
      tick();
      tick();
   endtask

   task automatic test_reset_in_compare();
      req_a = '0;
      req_b = '0;
      req_a[1*SD +: SD] = 28'h0000001;
      req_b[1*SD +: SD] = 28'h0000002;
      req_valid = 4'b0010;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rst_mid_grant: got %b want 0010", req_ready); end
      tick();
      req_valid = 4'b0101;
      rst = 1'b1;
      tick();
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_mid_ready_in_reset: got %b want 0000", req_ready); end
      rst = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_mid_lowest: got %b want 0001", req_ready); end
      n_vec++; if ({rsp_valid, rsp_id, rsp_less, rsp_equal} !== 5'b0) begin n_err++; $display("FAIL rst_mid_outputs: got %b want 00000", {rsp_valid, rsp_id, rsp_less, rsp_equal}); end
      req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_rsp%0d: got %b want 0", c, rsp_valid); end
      end
   endtask

`ifdef COMP_SHARE_ARB_SWAP_EN
   task automatic test_swap();
      logic [NREQ-1:0] rdy;
      logic vld_e, vld, lt, eq;
      logic [1:0] id;
      run_txn(0, 28'h0000005, 28'h0000009, rdy, vld_e, vld, id, lt, eq);
      n_vec++; if ({rsp_max, rsp_min} !== {28'h0000009, 28'h0000005}) begin n_err++; $display("FAIL swap_lt: got %h/%h want 0000009/0000005", rsp_max, rsp_min); end
      run_txn(0, 28'h0000009, 28'h0000005, rdy, vld_e, vld, id, lt, eq);
      n_vec++; if ({rsp_max, rsp_min} !== {28'h0000009, 28'h0000005}) begin n_err++; $display("FAIL swap_gt: got %h/%h want 0000009/0000005", rsp_max, rsp_min); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_compare_bounds();
      test_backpressure();
      test_reset_in_compare();
`ifdef COMP_SHARE_ARB_SWAP_EN
      test_swap();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
